// File: rtl/adc_share_pkg.sv
// Shared types and constants for the shared-converter scheduler.
package adc_share_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE,
    S_REQ,
    S_REL,
    S_ACK
  } state_t;

  // Channel indices as driven on adc_sel
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Default converter data width
  localparam int W_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the preferred channel
// under contention and toggles only when a contended grant is taken.
module rr_arb2
  import adc_share_pkg::*;
(
  input  logic       clock,
  input  logic       reset_,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr;

  // One-hot grant; contention resolved by the pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == CH1) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves away from the winner of a contended grant
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_)
      ptr <= CH0;
    else if (update && (req == 2'b11))
      ptr <= ~ptr;
  end

endmodule

// File: rtl/adc_share_sched.sv
// Shares one soc/eoc converter between two requester channels.
// Optional macro ADC_TIMEOUT_EN adds a per-phase watchdog with sticky err.
module adc_share_sched
  import adc_share_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                soc_0,
  output logic                eoc_0,
  output logic signed [W-1:0] v_0,
  input  logic                soc_1,
  output logic                eoc_1,
  output logic signed [W-1:0] v_1,
  output logic                adc_soc,
  input  logic                adc_eoc,
  input  logic signed [W-1:0] adc_v,
  output logic                adc_sel,
  output logic                err
);

  state_t     state, state_nx;
  logic       g;
  logic [1:0] grant;
  logic       grant_en;
  logic       soc_g;
  logic       tmo_hit;

  assign grant_en = (state == IDLE) && (|grant);
  assign soc_g    = (g == CH1) ? soc_1 : soc_0;
  assign adc_soc  = (state == S_REQ);

  rr_arb2 u_arb (
    .clock  (clock),
    .reset_ (reset_),
    .req    ({soc_1, soc_0}),
    .update (grant_en),
    .grant  (grant)
  );

`ifdef ADC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          expire;

  assign expire  = (cnt == CW'(TIMEOUT_CYC - 1));
  assign tmo_hit = expire && (((state == S_REQ) && adc_eoc) ||
                              ((state == S_REL) && !adc_eoc));

  // Phase cycle counter, restarted on every state change
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_)
      cnt <= '0;
    else if ((state != state_nx) || !((state == S_REQ) || (state == S_REL)))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Sticky timeout flag
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_)
      err <= 1'b0;
    else if (tmo_hit)
      err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; a stray adc_eoc edge only matters in the state awaiting it
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|grant) state_nx = S_REQ;
      S_REQ:   if (!adc_eoc || tmo_hit) state_nx = (adc_eoc) ? S_ACK : S_REL;
      S_REL:   if (adc_eoc || tmo_hit) state_nx = S_ACK;
      S_ACK:   if (!soc_g) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant latch, channel select, requester eoc and held result buses
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      g       <= CH0;
      adc_sel <= CH0;
      eoc_0   <= 1'b1;
      eoc_1   <= 1'b1;
      v_0     <= '0;
      v_1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            g       <= grant[1];
            adc_sel <= grant[1];
            if (grant[1]) eoc_1 <= 1'b0;
            else          eoc_0 <= 1'b0;
          end
        end
        S_REL: begin
          if (adc_eoc) begin
            if (g == CH1) v_1 <= adc_v;
            else          v_0 <= adc_v;
          end
        end
        S_ACK: begin
          if (!soc_g) begin
            if (g == CH1) eoc_1 <= 1'b1;
            else          eoc_0 <= 1'b1;
          end
        end
        default: ;
      endcase
      // An abandoned conversion returns zero to the requester
      if (tmo_hit) begin
        if (g == CH1) v_1 <= '0;
        else          v_0 <= '0;
      end
    end
  end

endmodule
